// File: rtl/commu_pkg.sv
// Shared constants and FSM state encoding for the UART protocol layer.
package commu_pkg;

  localparam logic [7:0] SOF_REQ = 8'hA5;
  localparam logic [7:0] SOF_RSP = 8'h5A;
  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] RSP_ERR = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_EXEC,
    ST_WAIT_Q,
    ST_RESP
  } state_e;

endpackage

// File: rtl/commu_txq.sv
// Response byte buffer (up to 3 bytes) with microsecond pacing toward a
// transmitter that has no ready/backpressure signal.
module commu_txq #(
  parameter int unsigned TX_GAP_US = 100
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pluse_us,
  input  logic       load_i,
  input  logic [1:0] len_i,
  input  logic [7:0] byte0_i,
  input  logic [7:0] byte1_i,
  input  logic [7:0] byte2_i,
  output logic [7:0] tx_data_o,
  output logic       tx_vld_o,
  output logic       busy_o
);

  localparam logic [15:0] GAP = 16'(TX_GAP_US);

  logic [7:0]  byte0_q, byte1_q, byte2_q;
  logic [1:0]  len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] gap_q, gap_d;
  logic        first_q, first_d;
  logic        busy_q, busy_d;
  logic        gap_done, more, fire;
  logic [7:0]  sel_byte;

  // A pulse coincident with a tx_vld cycle is not counted toward the gap.
  always_comb begin
    gap_done = busy_q && !first_q && pluse_us && (gap_q == GAP - 16'd1);
    more     = (idx_q < len_q);
    fire     = gap_done && more;
    tx_vld_o = first_q || fire;
    case (first_q ? 2'd0 : idx_q)
      2'd0:    sel_byte = byte0_q;
      2'd1:    sel_byte = byte1_q;
      default: sel_byte = byte2_q;
    endcase
    tx_data_o = tx_vld_o ? sel_byte : 8'h00;
    busy_o    = busy_q;
  end

  always_comb begin
    first_d = 1'b0;
    busy_d  = busy_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    len_d   = len_q;
    if (load_i) begin
      first_d = 1'b1;
      busy_d  = 1'b1;
      idx_d   = 2'd1;
      gap_d   = '0;
      len_d   = len_i;
    end else if (tx_vld_o) begin
      gap_d = '0;
      if (fire) idx_d = idx_q + 2'd1;
    end else if (gap_done) begin
      // Trailing gap after the last byte has elapsed.
      busy_d = 1'b0;
      gap_d  = '0;
    end else if (busy_q && pluse_us && (gap_q != GAP)) begin
      gap_d = gap_q + 16'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      gap_q   <= '0;
      len_q   <= '0;
    end else begin
      first_q <= first_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (load_i) begin
      byte0_q <= byte0_i;
      byte1_q <= byte1_i;
      byte2_q <= byte2_i;
    end
  end

endmodule

// File: rtl/commu_proto.sv
// UART frame parser: decodes A5-prefixed write/read requests, drives the fx
// register bus and queues the acknowledge/response frame for transmission.
module commu_proto
  import commu_pkg::*;
#(
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned TX_GAP_US = 100,
  parameter int unsigned RX_TMO_US = 2000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  output logic [31:0] fx_waddr,
  output logic [7:0]  fx_data,
  output logic        fx_wr,
  output logic [31:0] fx_raddr,
  output logic        fx_rd,
  input  logic [7:0]  fx_q
);

  localparam logic [15:0] TMO      = 16'(RX_TMO_US);
  localparam logic [2:0]  LAT_LAST = 3'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q;
  logic [31:0] addr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [2:0]  lat_q, lat_d;
  logic [31:0] waddr_q, raddr_q;
  logic [7:0]  wdata_q;
  logic        in_frame, tmo_hit, rx_take, lat_done;
  logic        txq_load, txq_busy;
  logic [1:0]  txq_len;
  logic [7:0]  txq_b1, txq_b2;

  assign in_frame = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign tmo_hit  = in_frame && (tmo_q == TMO);
  assign rx_take  = rx_vld && !tmo_hit;
  assign lat_done = (lat_q == LAT_LAST);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Bytes arriving in EXEC/WAIT_Q/RESP are ignored; a mid-frame A5 is payload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rx_vld && rx_data == SOF_REQ) state_d = ST_CMD;
      ST_CMD: begin
        if (tmo_hit)     state_d = ST_IDLE;
        else if (rx_vld) state_d = (rx_data == CMD_WR || rx_data == CMD_RD) ? ST_ADDR : ST_EXEC;
      end
      ST_ADDR: begin
        if (tmo_hit)                      state_d = ST_IDLE;
        else if (rx_vld && cnt_q == 2'd3) state_d = (cmd_q == CMD_WR) ? ST_DATA : ST_EXEC;
      end
      ST_DATA: begin
        if (tmo_hit)     state_d = ST_IDLE;
        else if (rx_vld) state_d = ST_EXEC;
      end
      ST_EXEC:   state_d = (cmd_q == CMD_RD) ? ST_WAIT_Q : ST_RESP;
      ST_WAIT_Q: if (lat_done) state_d = ST_RESP;
      ST_RESP:   if (!txq_busy) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fx_wr    = 1'b0;
    fx_rd    = 1'b0;
    txq_load = 1'b0;
    txq_len  = 2'd2;
    txq_b1   = cmd_q;
    txq_b2   = fx_q;
    case (state_q)
      ST_EXEC: begin
        fx_wr = (cmd_q == CMD_WR);
        fx_rd = (cmd_q == CMD_RD);
        if (cmd_q != CMD_RD) begin
          txq_load = 1'b1;
          txq_b1   = (cmd_q == CMD_WR) ? CMD_WR : RSP_ERR;
        end
      end
      ST_WAIT_Q: begin
        // fx_q is captured into the response buffer on this cycle.
        if (lat_done) begin
          txq_load = 1'b1;
          txq_len  = 2'd3;
          txq_b1   = CMD_RD;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = (state_q == ST_ADDR) ? (rx_take ? cnt_q + 2'd1 : cnt_q) : 2'd0;
    lat_d = (state_q == ST_WAIT_Q) ? lat_q + 3'd1 : 3'd0;
    if (!in_frame || rx_vld)       tmo_d = '0;
    else if (pluse_us && !tmo_hit) tmo_d = tmo_q + 16'd1;
    else                           tmo_d = tmo_q;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lat_q <= '0;
      tmo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      tmo_q <= tmo_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (state_q == ST_CMD && rx_take)  cmd_q  <= rx_data;
    if (state_q == ST_ADDR && rx_take) addr_q <= {addr_q[23:0], rx_data};
  end

  // Bus address/data outputs hold the last access and clear on reset.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
    end else begin
      if (state_q == ST_DATA && rx_take) begin
        waddr_q <= addr_q;
        wdata_q <= rx_data;
      end
      if (state_q == ST_ADDR && rx_take && cnt_q == 2'd3 && cmd_q == CMD_RD)
        raddr_q <= {addr_q[23:0], rx_data};
    end
  end

  assign fx_waddr = waddr_q;
  assign fx_data  = wdata_q;
  assign fx_raddr = raddr_q;

  commu_txq #(
    .TX_GAP_US (TX_GAP_US)
  ) u_txq (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .pluse_us  (pluse_us),
    .load_i    (txq_load),
    .len_i     (txq_len),
    .byte0_i   (SOF_RSP),
    .byte1_i   (txq_b1),
    .byte2_i   (txq_b2),
    .tx_data_o (tx_data),
    .tx_vld_o  (tx_vld),
    .busy_o    (txq_busy)
  );

endmodule

// File: tb/tb_commu_proto.sv
// Bench for commu_proto: two instances (RD_LAT=1 and RD_LAT=3) share the rx
// stimulus; a scoreboard of expected bus accesses and tx bytes is replayed per instance.
module tb_commu_proto;

  localparam int GAP  = 5;
  localparam int TMO  = 20;
  localparam int PDIV = 4;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        pluse_us = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic [7:0]  tx_data [2];
  logic        tx_vld [2];
  logic [31:0] fx_waddr [2];
  logic [7:0]  fx_data [2];
  logic        fx_wr [2];
  logic [31:0] fx_raddr [2];
  logic        fx_rd [2];
  logic [7:0]  fx_q [2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rx_cyc = 0;

  // Scoreboard: tx entries are {first, is_read, byte}; bus entries {addr, data}.
  logic [9:0]  exp_tx [$];
  logic [39:0] exp_wr [$];
  logic [39:0] exp_rd [$];
  int tx_ptr [2];
  int wr_ptr [2];
  int rd_ptr [2];
  int pcnt [2];
  int rd_cyc [2];
  logic [7:0] rd_val [2];

  commu_proto #(.RD_LAT(1), .TX_GAP_US(GAP), .RX_TMO_US(TMO)) dut0 (
    .clk_sys(clk_sys), .rst_n(rst_n), .pluse_us(pluse_us),
    .rx_data(rx_data), .rx_vld(rx_vld),
    .tx_data(tx_data[0]), .tx_vld(tx_vld[0]),
    .fx_waddr(fx_waddr[0]), .fx_data(fx_data[0]), .fx_wr(fx_wr[0]),
    .fx_raddr(fx_raddr[0]), .fx_rd(fx_rd[0]), .fx_q(fx_q[0])
  );

  commu_proto #(.RD_LAT(3), .TX_GAP_US(GAP), .RX_TMO_US(TMO)) dut1 (
    .clk_sys(clk_sys), .rst_n(rst_n), .pluse_us(pluse_us),
    .rx_data(rx_data), .rx_vld(rx_vld),
    .tx_data(tx_data[1]), .tx_vld(tx_vld[1]),
    .fx_waddr(fx_waddr[1]), .fx_data(fx_data[1]), .fx_wr(fx_wr[1]),
    .fx_raddr(fx_raddr[1]), .fx_rd(fx_rd[1]), .fx_q(fx_q[1])
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    int pdiv;
    pdiv = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      pdiv = (pdiv + 1) % PDIV;
      pluse_us = (pdiv == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk_sys) begin
    logic [9:0]  et;
    logic [39:0] eb;
    int          want;
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        if (fx_wr[i] && fx_rd[i]) begin
          n_cmp++; n_err++;
          $display("FAIL strobe_excl inst%0d: fx_wr and fx_rd both 1, required exclusive", i);
        end
        if (fx_wr[i]) begin
          n_cmp++;
          if (wr_ptr[i] >= exp_wr.size()) begin
            n_err++;
            $display("FAIL fx_wr inst%0d: unexpected write %h/%h", i, fx_waddr[i], fx_data[i]);
          end else begin
            eb = exp_wr[wr_ptr[i]];
            wr_ptr[i]++;
            if ({fx_waddr[i], fx_data[i]} !== eb || cyc !== rx_cyc + 1) begin
              n_err++;
              $display("FAIL fx_wr inst%0d: got %h/%h cyc %0d, required %h/%h cyc %0d",
                       i, fx_waddr[i], fx_data[i], cyc, eb[39:8], eb[7:0], rx_cyc + 1);
            end
          end
        end
        if (fx_rd[i]) begin
          n_cmp++;
          if (rd_ptr[i] >= exp_rd.size()) begin
            n_err++;
            $display("FAIL fx_rd inst%0d: unexpected read %h", i, fx_raddr[i]);
          end else begin
            eb = exp_rd[rd_ptr[i]];
            rd_ptr[i]++;
            rd_cyc[i] = cyc;
            rd_val[i] = eb[7:0];
            if (fx_raddr[i] !== eb[39:8] || cyc !== rx_cyc + 1) begin
              n_err++;
              $display("FAIL fx_rd inst%0d: got %h cyc %0d, required %h cyc %0d",
                       i, fx_raddr[i], cyc, eb[39:8], rx_cyc + 1);
            end
          end
        end
        if (tx_vld[i]) begin
          n_cmp++;
          if (tx_ptr[i] >= exp_tx.size()) begin
            n_err++;
            $display("FAIL tx inst%0d: unexpected byte %h at cyc %0d", i, tx_data[i], cyc);
          end else begin
            et = exp_tx[tx_ptr[i]];
            tx_ptr[i]++;
            if (et[9]) begin
              want = rx_cyc + 2 + (et[8] ? lat_of(i) : 0);
              if (tx_data[i] !== et[7:0] || cyc !== want) begin
                n_err++;
                $display("FAIL tx_first inst%0d: got %h cyc %0d, required %h cyc %0d",
                         i, tx_data[i], cyc, et[7:0], want);
              end
            end else if (tx_data[i] !== et[7:0] || pluse_us !== 1'b1 || pcnt[i] != GAP - 1) begin
              n_err++;
              $display("FAIL tx_next inst%0d: got %h pulse %0d prior %0d, required %h pulse 1 prior %0d",
                       i, tx_data[i], pluse_us, pcnt[i], et[7:0], GAP - 1);
            end
          end
          pcnt[i] = 0;
        end else if (pluse_us) begin
          pcnt[i]++;
        end
      end
      fx_q[i] = (cyc == rd_cyc[i] + lat_of(i)) ? rd_val[i] : 8'h00;
    end
    if (rx_vld) rx_cyc = cyc;
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk_sys);
    #1 rx_data = b; rx_vld = 1'b1;
    @(posedge clk_sys);
    #1 rx_vld = 1'b0; rx_data = 8'h00;
  endtask

  task automatic push_write(input logic [31:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    exp_tx.push_back({2'b10, 8'h5A});
    exp_tx.push_back({2'b00, 8'h01});
  endtask

  task automatic push_read(input logic [31:0] a, input logic [7:0] q);
    exp_rd.push_back({a, q});
    exp_tx.push_back({2'b11, 8'h5A});
    exp_tx.push_back({2'b00, 8'h02});
    exp_tx.push_back({2'b00, q});
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                            input logic [7:0] d, input bit with_data);
    send(8'hA5); send(cmd);
    send(a[31:24]); send(a[23:16]); send(a[15:8]); send(a[7:0]);
    if (with_data) send(d);
  endtask

  // Wait until both instances produced everything queued, then one full gap.
  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((tx_ptr[0] < exp_tx.size() || tx_ptr[1] < exp_tx.size() ||
            wr_ptr[0] < exp_wr.size() || wr_ptr[1] < exp_wr.size() ||
            rd_ptr[0] < exp_rd.size() || rd_ptr[1] < exp_rd.size()) && k < 3000) begin
      @(posedge clk_sys);
      k++;
    end
    n_cmp++;
    if (k >= 3000) begin
      n_err++;
      $display("FAIL %s_drain: tx %0d/%0d of %0d, wr %0d/%0d of %0d, rd %0d/%0d of %0d",
               tag, tx_ptr[0], tx_ptr[1], exp_tx.size(), wr_ptr[0], wr_ptr[1], exp_wr.size(),
               rd_ptr[0], rd_ptr[1], exp_rd.size());
    end
    repeat ((GAP + 3) * PDIV) @(posedge clk_sys);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_vld = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tx_ptr[i] = 0; wr_ptr[i] = 0; rd_ptr[i] = 0; pcnt[i] = 0;
      rd_cyc[i] = -100; rd_val[i] = 8'h00;
    end
    repeat (3) @(posedge clk_sys);
    #2;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({tx_vld[i], tx_data[i], fx_wr[i], fx_rd[i], fx_waddr[i], fx_data[i], fx_raddr[i]} !== 83'd0) begin
        n_err++;
        $display("FAIL reset_outputs inst%0d: got tx %b/%h wr %b rd %b wa %h wd %h ra %h, required all 0",
                 i, tx_vld[i], tx_data[i], fx_wr[i], fx_rd[i], fx_waddr[i], fx_data[i], fx_raddr[i]);
      end
    end
    @(posedge clk_sys);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk_sys);
  endtask

  task automatic test_write();
    push_write(32'h0000_1234, 8'h5C);
    send_frame(8'h01, 32'h0000_1234, 8'h5C, 1'b1);
    wait_idle("write");
  endtask

  task automatic test_read();
    push_read(32'h8000_0004, 8'hC3);
    send_frame(8'h02, 32'h8000_0004, 8'h00, 1'b0);
    wait_idle("read");
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (fx_raddr[i] !== 32'h8000_0004 || fx_waddr[i] !== 32'h0000_1234 || fx_data[i] !== 8'h5C) begin
        n_err++;
        $display("FAIL read_hold inst%0d: ra %h wa %h wd %h, required 80000004 00001234 5c",
                 i, fx_raddr[i], fx_waddr[i], fx_data[i]);
      end
    end
  endtask

  task automatic test_noise();
    send(8'h00); send(8'hFF); send(8'h5A);
    push_write(32'hDEAD_BEEF, 8'h77);
    send_frame(8'h01, 32'hDEAD_BEEF, 8'h77, 1'b1);
    wait_idle("noise");
  endtask

  task automatic test_timeout();
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22);
    repeat ((TMO + 5) * PDIV) @(posedge clk_sys);
    push_read(32'hAABB_CCDD, 8'h3C);
    send_frame(8'h02, 32'hAABB_CCDD, 8'h00, 1'b0);
    wait_idle("timeout");
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (fx_raddr[i] !== 32'hAABB_CCDD) begin
        n_err++;
        $display("FAIL timeout_addr inst%0d: got %h, required aabbccdd", i, fx_raddr[i]);
      end
    end
  endtask

  task automatic test_unknown();
    exp_tx.push_back({2'b10, 8'h5A});
    exp_tx.push_back({2'b00, 8'hFF});
    send(8'hA5); send(8'h07);
    wait_idle("unknown");
    push_write(32'h0000_0055, 8'h99);
    send_frame(8'h01, 32'h0000_0055, 8'h99, 1'b1);
    wait_idle("after_unknown");
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (fx_waddr[i] !== 32'h0000_0055 || fx_data[i] !== 8'h99 || fx_raddr[i] !== 32'hAABB_CCDD) begin
        n_err++;
        $display("FAIL unknown_next inst%0d: wa %h wd %h ra %h, required 00000055 99 aabbccdd",
                 i, fx_waddr[i], fx_data[i], fx_raddr[i]);
      end
    end
  endtask

  task automatic test_reset_mid_resp();
    int k;
    exp_wr.push_back({32'h0BAD_F00D, 8'h42});
    exp_tx.push_back({2'b10, 8'h5A});
    send_frame(8'h01, 32'h0BAD_F00D, 8'h42, 1'b1);
    k = 0;
    while ((tx_ptr[0] < exp_tx.size() || tx_ptr[1] < exp_tx.size()) && k < 200) begin
      @(posedge clk_sys);
      k++;
    end
    n_cmp++;
    if (k >= 200) begin
      n_err++;
      $display("FAIL rstmid_first: first byte seen %0d/%0d, required both", tx_ptr[0], tx_ptr[1]);
    end
    repeat (6) @(posedge clk_sys);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({tx_vld[i], tx_data[i], fx_wr[i], fx_rd[i], fx_waddr[i], fx_data[i], fx_raddr[i]} !== 83'd0) begin
        n_err++;
        $display("FAIL rstmid_clear inst%0d: got tx %b/%h wa %h wd %h ra %h, required all 0",
                 i, tx_vld[i], tx_data[i], fx_waddr[i], fx_data[i], fx_raddr[i]);
      end
    end
    exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
    for (int i = 0; i < 2; i++) begin
      tx_ptr[i] = 0; wr_ptr[i] = 0; rd_ptr[i] = 0; pcnt[i] = 0; rd_cyc[i] = -100;
    end
    repeat (3) @(posedge clk_sys);
    #2 rst_n = 1'b1;
    repeat ((2 * GAP + 4) * PDIV) @(posedge clk_sys);
    #2;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (tx_ptr[i] != 0 || {fx_waddr[i], fx_data[i], fx_raddr[i]} !== 72'd0) begin
        n_err++;
        $display("FAIL rstmid_after inst%0d: tx bytes %0d wa %h wd %h ra %h, required 0 bytes and zeros",
                 i, tx_ptr[i], fx_waddr[i], fx_data[i], fx_raddr[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_noise();
    test_timeout();
    test_unknown();
    test_reset_mid_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
